// File: rtl/jesd204b_tx_pkg.sv
// Shared definitions for the JESD204B transmit link layer.
//   tx_state_e      : link state (code group sync, lane alignment, user data)
//   K28_x           : control characters used on the link
//   OCTETS_PER_BEAT : octets carried by one link-clock beat
package jesd204b_tx_pkg;

    typedef enum logic [1:0] {
        CGS  = 2'd0,
        ILAS = 2'd1,
        DATA = 2'd2
    } tx_state_e;

    localparam logic [7:0] K28_5 = 8'hBC;  // /K/ comma, code group sync
    localparam logic [7:0] K28_0 = 8'h1C;  // /R/ multiframe start in ILAS
    localparam logic [7:0] K28_3 = 8'h7C;  // /A/ multiframe end in ILAS
    localparam logic [7:0] K28_4 = 8'h9C;  // /Q/ start of link configuration

    localparam int OCTETS_PER_BEAT = 4;

endpackage

// File: rtl/jesd204b_tx_link_if.sv
// Bundle of the link-layer signals between the user side / receiver handshake
// and the transmit link layer.
//   sync_ni    : SYNC~ from the receiver, active-low
//   sysref_i   : SYSREF, rising edge realigns the LMFC
//   cfg_i      : 14 ILAS configuration octets, octet n at [8n+7:8n]
//   tx_data_i  : user beat, octet 0 in [7:0] goes first
//   tx_ready_o : tx_data_i is consumed in this cycle
//   data_o     : 4 octets to the 8b/10b encoder
//   charisk_o  : per-octet K-character flags
//   lmfc_o     : pulse on the first beat of each multiframe
// The link layer uses the master modport, the environment the slave modport.
interface jesd204b_tx_link_if;

    logic         sync_ni;
    logic         sysref_i;
    logic [111:0] cfg_i;
    logic [31:0]  tx_data_i;
    logic         tx_ready_o;
    logic [31:0]  data_o;
    logic [3:0]   charisk_o;
    logic         lmfc_o;

    modport master (
        input  sync_ni, sysref_i, cfg_i, tx_data_i,
        output tx_ready_o, data_o, charisk_o, lmfc_o
    );

    modport slave (
        output sync_ni, sysref_i, cfg_i, tx_data_i,
        input  tx_ready_o, data_o, charisk_o, lmfc_o
    );

endinterface

// File: rtl/jesd204b_lmfc_counter.sv
// Local multiframe clock counter.
//   clk_i, rst_i : link clock, synchronous active-high reset
//   sysref_i     : SYSREF; its registered rising edge forces the count to 0
//   cnt_next_o   : beat index the counter takes at the next clock edge
//   realign_o    : the next edge is a SYSREF-forced jump that breaks the
//                  running multiframe (not a coincident natural wrap)
//   lmfc_o       : registered pulse while the count is 0
module jesd204b_lmfc_counter #(
    parameter int BEATS = 16,
    parameter int CNT_W = $clog2(BEATS)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             sysref_i,
    output logic [CNT_W-1:0] cnt_next_o,
    output logic             realign_o,
    output logic             lmfc_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

    logic             sysref_q;
    logic             sysref_qq;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             lmfc_q;
    logic             edge_w;
    logic             at_end_w;

    always_comb begin
        edge_w   = sysref_q & ~sysref_qq;
        at_end_w = (cnt_q == LAST);
        cnt_d    = (edge_w || at_end_w) ? '0 : cnt_q + CNT_W'(1);
        // A periodic SYSREF that lands on the natural wrap must not disturb
        // the link, so only a jump away from the running phase is reported.
        realign_o  = edge_w & ~at_end_w;
        cnt_next_o = cnt_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sysref_q  <= 1'b0;
            sysref_qq <= 1'b0;
            cnt_q     <= '0;
            lmfc_q    <= 1'b0;
        end else begin
            sysref_q  <= sysref_i;
            sysref_qq <= sysref_q;
            cnt_q     <= cnt_d;
            lmfc_q    <= (cnt_d == '0);
        end
    end

    assign lmfc_o = lmfc_q;

endmodule

// File: rtl/jesd204b_tx_link.sv
// Single-lane JESD204B transmit link layer: emits the K28.5 code group sync
// stream, the initial lane alignment sequence, then registered user data.
//   clk_i, rst_i : link clock (one 4-octet beat per cycle), sync active-high reset
//   link         : jesd204b_tx_link_if.master (SYNC~, SYSREF, ILAS config,
//                  user data/ready, encoder octets, K flags, LMFC pulse)
// All outputs are registered. Next-state logic works on the beat index the
// LMFC counter will hold after the edge, so the octets on data_o always
// belong to the multiframe position currently shown by the counter.
module jesd204b_tx_link
    import jesd204b_tx_pkg::*;
#(
    parameter int OCTETS_PER_FRAME = 2,
    parameter int FRAMES_PER_MF    = 32,   // F*K: multiple of 4, 16..1024
    parameter int ILAS_MF          = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    jesd204b_tx_link_if.master        link
);

    localparam int BEATS = OCTETS_PER_FRAME * FRAMES_PER_MF / OCTETS_PER_BEAT;
    localparam int CNT_W = $clog2(BEATS);
    localparam int P_W   = CNT_W + 2;
    localparam int MF_W  = (ILAS_MF > 1) ? $clog2(ILAS_MF) : 1;

    localparam logic [CNT_W-1:0] BEAT_LAST = CNT_W'(BEATS - 1);
    localparam logic [P_W-1:0]   P_LAST    = P_W'(4 * BEATS - 1);
    localparam logic [MF_W-1:0]  MF_LAST   = MF_W'(ILAS_MF - 1);

    localparam logic [1:0] ST_CGS  = CGS;
    localparam logic [1:0] ST_ILAS = ILAS;
    localparam logic [1:0] ST_DATA = DATA;

    logic [CNT_W-1:0] cnt_nxt;
    logic             realign;
    logic             lmfc;

    logic [1:0]       state_q,    state_d;
    logic [MF_W-1:0]  mf_q,       mf_d;
    logic             seen_q,     seen_d;
    logic             sync_low_q, sync_low_d;
    logic [31:0]      data_q,     data_d;
    logic [3:0]       charisk_q,  charisk_d;
    logic             ready_q,    ready_d;
    logic             resync;
    logic [8:0]       oct;

    jesd204b_lmfc_counter #(
        .BEATS (BEATS),
        .CNT_W (CNT_W)
    ) u_lmfc (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .sysref_i   (link.sysref_i),
        .cnt_next_o (cnt_nxt),
        .realign_o  (realign),
        .lmfc_o     (lmfc)
    );

    // ILAS octet at multiframe position p, returned as {is_k, octet}.
    // /A/ wins over a configuration slot in the degenerate 16-octet multiframe.
    function automatic logic [8:0] ilas_octet(input logic [P_W-1:0] p,
                                              input logic           second_mf,
                                              input logic [111:0]   cfg);
        logic [8:0] r;
        r = {1'b0, 8'(p)};
        if (p == '0)
            r = {1'b1, K28_0};
        else if (p == P_LAST)
            r = {1'b1, K28_3};
        else if (second_mf && p == P_W'(1))
            r = {1'b1, K28_4};
        else if (second_mf && p <= P_W'(15))
            r = {1'b0, cfg[8 * (int'(p) - 2) +: 8]};
        return r;
    endfunction

    always_comb begin
        state_d    = state_q;
        mf_d       = mf_q;
        seen_d     = seen_q;
        sync_low_d = ~link.sync_ni;
        // Two consecutive low samples of SYNC~ request a restart.
        resync     = (state_q != ST_CGS) && ~link.sync_ni && sync_low_q;

        case (state_q)
            ST_CGS: begin
                if (!link.sync_ni)
                    seen_d = 1'b1;
                if (cnt_nxt == '0 && link.sync_ni && seen_q) begin
                    state_d = ST_ILAS;
                    mf_d    = '0;
                    seen_d  = 1'b0;
                end
            end
            ST_ILAS: begin
                if (resync) begin
                    state_d = ST_CGS;
                    seen_d  = 1'b1;
                end else if (realign) begin
                    mf_d = '0;
                end else if (cnt_nxt == '0) begin
                    if (mf_q == MF_LAST)
                        state_d = ST_DATA;
                    else
                        mf_d = mf_q + MF_W'(1);
                end
            end
            ST_DATA: begin
                if (resync) begin
                    state_d = ST_CGS;
                    seen_d  = 1'b1;
                end
            end
            default: state_d = ST_CGS;
        endcase

        data_d    = {4{K28_5}};
        charisk_d = 4'hF;
        ready_d   = 1'b0;
        oct       = '0;
        case (state_d)
            ST_ILAS: begin
                for (int i = 0; i < OCTETS_PER_BEAT; i++) begin
                    oct = ilas_octet({cnt_nxt, 2'(i)}, (mf_d == MF_W'(1)), link.cfg_i);
                    charisk_d[i]      = oct[8];
                    data_d[8*i +: 8]  = oct[7:0];
                end
                // Take the first user beat during the last ILAS beat so it
                // lands on the following multiframe boundary without a gap.
                ready_d = (mf_d == MF_LAST) && (cnt_nxt == BEAT_LAST);
            end
            ST_DATA: begin
                data_d    = link.tx_data_i;
                charisk_d = 4'h0;
                ready_d   = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_CGS;
            mf_q       <= '0;
            seen_q     <= 1'b0;
            sync_low_q <= 1'b0;
            data_q     <= '0;
            charisk_q  <= '0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            mf_q       <= mf_d;
            seen_q     <= seen_d;
            sync_low_q <= sync_low_d;
            data_q     <= data_d;
            charisk_q  <= charisk_d;
            ready_q    <= ready_d;
        end
    end

    assign link.data_o     = data_q;
    assign link.charisk_o  = charisk_q;
    assign link.tx_ready_o = ready_q;
    assign link.lmfc_o     = lmfc;

endmodule

// File: tb/tb_jesd204b_tx_link.sv
// Directed bench for jesd204b_tx_link at default parameters (16 beats/MF,
// 4-multiframe ILAS). Outputs are sampled 1 time unit after each rising edge.
module tb_jesd204b_tx_link;

    logic clk_i = 1'b0;
    logic rst_i;
    int   checks = 0;
    int   errors = 0;

    jesd204b_tx_link_if lnk ();

    jesd204b_tx_link dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .link  (lnk)
    );

    always #5 clk_i = ~clk_i;

    // {data, charisk, ready, lmfc}
    logic [37:0] obs;
    assign obs = {lnk.data_o, lnk.charisk_o, lnk.tx_ready_o, lnk.lmfc_o};

    localparam logic [37:0] BC_IDLE = {32'hBCBCBCBC, 4'hF, 1'b0, 1'b0};

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        int pulses = 0;
        int first  = 0;
        int bad    = 0;
        rst_i         = 1'b1;
        lnk.sync_ni   = 1'b0;
        lnk.sysref_i  = 1'b0;
        lnk.tx_data_i = 32'hDEADBEEF;
        for (int n = 0; n < 14; n++) lnk.cfg_i[8*n +: 8] = 8'(8'h10 + n);
        repeat (3) tick();
        checks++;
        if (obs !== 38'h0) begin
            errors++;
            $display("FAIL reset_hold: got %h want %h", obs, 38'h0);
        end
        rst_i = 1'b0;
        tick();
        checks++;
        if (obs !== BC_IDLE) begin
            errors++;
            $display("FAIL cgs_first: got %h want %h", obs, BC_IDLE);
        end
        for (int k = 2; k <= 32; k++) begin
            tick();
            if (lnk.lmfc_o === 1'b1) begin
                pulses++;
                if (first == 0) first = k;
            end
            if ({lnk.data_o, lnk.charisk_o, lnk.tx_ready_o} !== BC_IDLE[37:1]) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL cgs_stream: got %0d bad beats want 0", bad);
        end
        checks++;
        if (pulses !== 2 || first !== 16) begin
            errors++;
            $display("FAIL lmfc_period: got %0d pulses first at %0d want 2 at 16", pulses, first);
        end
    endtask

    task automatic test_cgs_to_ilas();
        int bad = 0;
        repeat (5) tick();          // count 5
        lnk.sync_ni = 1'b1;
        repeat (10) begin
            tick();
            if (obs !== BC_IDLE) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL cgs_wait_boundary: got %0d bad beats want 0", bad);
        end
        tick();
        checks++;
        if (obs !== {32'h0302011C, 4'b0001, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL ilas_mf0_b0: got %h want %h", obs, {32'h0302011C, 4'b0001, 1'b0, 1'b1});
        end
        repeat (15) tick();
        checks++;
        if (obs !== {32'h7C3E3D3C, 4'b1000, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL ilas_mf0_b15: got %h want %h", obs, {32'h7C3E3D3C, 4'b1000, 1'b0, 1'b0});
        end
        tick();
        checks++;
        if (obs !== {32'h11109C1C, 4'b0011, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL ilas_mf1_b0: got %h want %h", obs, {32'h11109C1C, 4'b0011, 1'b0, 1'b1});
        end
        repeat (3) tick();
        checks++;
        if (obs !== {32'h1D1C1B1A, 4'b0000, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL ilas_mf1_b3: got %h want %h", obs, {32'h1D1C1B1A, 4'b0000, 1'b0, 1'b0});
        end
    endtask

    task automatic test_ilas_to_data();
        repeat (43) tick();         // multiframe 3, beat 14
        checks++;
        if (obs !== {32'h3B3A3938, 4'b0000, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL ilas_mf3_b14: got %h want %h", obs, {32'h3B3A3938, 4'b0000, 1'b0, 1'b0});
        end
        tick();
        checks++;
        if (obs !== {32'h7C3E3D3C, 4'b1000, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL ilas_last_ready: got %h want %h", obs, {32'h7C3E3D3C, 4'b1000, 1'b1, 1'b0});
        end
        tick();
        checks++;
        if (obs !== {32'hDEADBEEF, 4'b0000, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL data_first: got %h want %h", obs, {32'hDEADBEEF, 4'b0000, 1'b1, 1'b1});
        end
    endtask

    task automatic test_data_sync();
        int n     = 0;
        int bad   = 0;
        bit found = 1'b0;
        lnk.tx_data_i = 32'h11223344;
        tick();
        checks++;
        if (obs !== {32'h11223344, 4'b0000, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL data_latency: got %h want %h", obs, {32'h11223344, 4'b0000, 1'b1, 1'b0});
        end
        lnk.tx_data_i = 32'h55667788;
        lnk.sync_ni   = 1'b0;
        tick();
        lnk.tx_data_i = 32'h99AABBCC;
        lnk.sync_ni   = 1'b1;
        tick();
        checks++;
        if (obs !== {32'h99AABBCC, 4'b0000, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL single_low_ignored: got %h want %h", obs, {32'h99AABBCC, 4'b0000, 1'b1, 1'b0});
        end
        lnk.tx_data_i = 32'h0BADF00D;
        lnk.sync_ni   = 1'b0;
        tick();
        checks++;
        if (obs !== {32'h0BADF00D, 4'b0000, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL first_low: got %h want %h", obs, {32'h0BADF00D, 4'b0000, 1'b1, 1'b0});
        end
        tick();
        checks++;
        if (obs !== BC_IDLE) begin
            errors++;
            $display("FAIL resync: got %h want %h", obs, BC_IDLE);
        end
        tick();                     // count 6, still low
        lnk.sync_ni = 1'b1;
        while (!found && n < 20) begin
            tick();
            n++;
            if (lnk.lmfc_o === 1'b1) found = 1'b1;
            else if (obs !== BC_IDLE) bad++;
        end
        checks++;
        if (!found || n !== 10 || bad !== 0) begin
            errors++;
            $display("FAIL resync_wait: got found=%0d after %0d beats bad=%0d want 1 after 10 bad=0", found, n, bad);
        end
        checks++;
        if (obs !== {32'h0302011C, 4'b0001, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL ilas_restart: got %h want %h", obs, {32'h0302011C, 4'b0001, 1'b0, 1'b1});
        end
    endtask

    task automatic test_sysref_realign();
        repeat (23) tick();         // multiframe 1, beat 7
        checks++;
        if (obs !== {32'h1F1E1D1C, 4'b0000, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL ilas_mf1_b7: got %h want %h", obs, {32'h1F1E1D1C, 4'b0000, 1'b0, 1'b0});
        end
        lnk.sysref_i = 1'b1;
        tick();
        checks++;
        if (obs !== {32'h23222120, 4'b0000, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL sysref_reg_beat: got %h want %h", obs, {32'h23222120, 4'b0000, 1'b0, 1'b0});
        end
        tick();
        checks++;
        if (obs !== {32'h0302011C, 4'b0001, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL sysref_realign: got %h want %h", obs, {32'h0302011C, 4'b0001, 1'b0, 1'b1});
        end
        tick();
        checks++;
        if (obs !== {32'h07060504, 4'b0000, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL sysref_mf0_b1: got %h want %h", obs, {32'h07060504, 4'b0000, 1'b0, 1'b0});
        end
    endtask

    task automatic test_reset_mid_ilas();
        int  n     = 0;
        bit  found = 1'b0;
        lnk.sysref_i = 1'b0;
        rst_i        = 1'b1;
        tick();
        checks++;
        if (obs !== 38'h0) begin
            errors++;
            $display("FAIL reset_mid_ilas: got %h want %h", obs, 38'h0);
        end
        rst_i = 1'b0;
        tick();
        checks++;
        if (obs !== BC_IDLE) begin
            errors++;
            $display("FAIL post_reset_cgs: got %h want %h", obs, BC_IDLE);
        end
        // SYNC~ stays high throughout, so no low was seen and CGS must hold.
        while (!found && n < 20) begin
            tick();
            n++;
            if (lnk.lmfc_o === 1'b1) found = 1'b1;
        end
        checks++;
        if (!found || n !== 15 || obs !== {32'hBCBCBCBC, 4'hF, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL cgs_needs_low: got found=%0d n=%0d obs=%h want 1 15 %h", found, n, obs, {32'hBCBCBCBC, 4'hF, 1'b0, 1'b1});
        end
    endtask

    initial begin
        test_reset();
        test_cgs_to_ilas();
        test_ilas_to_data();
        test_data_sync();
        test_sysref_realign();
        test_reset_mid_ilas();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
